serial_tx: RTL and testbench
============================

# serial_tx

Asynchronous serial transmitter: accepts a parallel byte over a load/ready handshake and shifts it out LSB-first on a single line as a start/data/[parity]/stop frame. Each bit is held for a programmable number of clock cycles. It is the transmit end of the bit-serial link whose receive side is built around our sample and bit-in-character counters. It sits between the control logic that produces bytes and the off-chip TX pin.

## Interface
- CLKS_PER_BIT, default 16: clock cycles per serial bit; legal values are 2 and above.
- DATA_BITS, default 8: data bits per frame; legal range is 5 to 8.
- PARITY_EN, default 0: 1 inserts an even-parity bit after the data bits.
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- data_in  input  8  byte to send; only bits [DATA_BITS-1:0] are used; sampled on the accept edge.
- load  input  1  request to send data_in.
- ready  output  1  high when the block can accept a byte; registered.
- tx_out  output  1  serial line; idles high; registered.
- done  output  1  one-cycle pulse when a frame's stop bit has completed; registered.

## Operation
- Reset values:
  - tx_out=1, ready=1, done=0.
  - State IDLE; shift register, bit counter and cycle counter all 0.
- Accept rule: a byte is accepted on a rising edge where load=1 and ready=1.
  - data_in is latched into the shift register at that edge.
  - The parity bit is the XOR of data_in[DATA_BITS-1:0], computed at that edge.
  - load while ready=0 is ignored. It is not queued, and the data is not sampled.
- States:
  - IDLE: tx_out=1, ready=1. Goes to START on accept.
  - START: tx_out=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: tx_out=shift[0]. After CLKS_PER_BIT cycles, shift right one and increment the bit counter. After DATA_BITS bits, go to PARITY if PARITY_EN=1, else STOP.
  - PARITY: tx_out=parity for CLKS_PER_BIT cycles, then STOP.
  - STOP: tx_out=1 for CLKS_PER_BIT cycles, then IDLE.
- Counters:
  - Cycle counter is $clog2(CLKS_PER_BIT) bits wide. It counts 0..CLKS_PER_BIT-1, wraps to 0 on each bit boundary, and never free-runs outside a frame.
  - Bit counter is 3 bits wide and counts 0..DATA_BITS-1.
- Frame length is (2 + DATA_BITS + PARITY_EN) × CLKS_PER_BIT cycles.
- done pulses on the edge where STOP exits to IDLE, in the same cycle that ready rises.
- Back-to-back frames: if load=1 in the first IDLE cycle after a frame, the next START begins on the following edge.
  - This gives exactly one idle-high cycle between the stop bit and the next start bit.
  - No other gap is permitted.
- Reset mid-frame:
  - tx_out returns to 1 immediately, without waiting for a clock.
  - The frame is abandoned, with no done pulse.
  - ready=1 is asserted, and transmission does not resume after reset releases.
- data_in changing after the accept edge has no effect on the frame in flight.

## Timing
- Accept to line: tx_out falls on the accept edge itself (registered), and ready falls on the same edge.
- Every bit, including start and stop, is held exactly CLKS_PER_BIT cycles, with no off-by-one on the first or last bit.
- Last stop cycle to ready/done: 1 edge. ready and done are both high in the first IDLE cycle.
- Minimum accept-to-accept period is frame length + 1 cycle.
- All outputs are glitch-free register outputs, and there are no combinational paths from inputs to outputs.

## Test plan
- Reset check: hold rst for 3 cycles, then release with load=0 → tx_out=1, ready=1, done=0 throughout; no line activity for 200 cycles.
- Basic frame: defaults, send 8'hA5.
  - Required tx_out, 16 cycles per bit: 0, then 1,0,1,0,0,1,0,1, then 1.
  - Frame is 160 cycles; ready is low for exactly 160 cycles; one done pulse.
- Parity frame: PARITY_EN=1, CLKS_PER_BIT=4.
  - Send 8'h07: data 1,1,1,0,0,0,0,0, parity 1, stop 1; frame is 44 cycles.
  - Send 8'h03: parity 0.
- Back-to-back: hold load=1 with 8'h00 then 8'hFF → exactly 1 idle-high cycle between the first stop bit and the second start bit; 2 done pulses.
- Busy load: pulse load with 8'h3C in the middle of an 8'h55 frame → the 8'h55 frame is bit-exact, and no 8'h3C frame follows.
- Reset mid-frame: assert rst during data bit 4 of 8'h00 → tx_out=1 within the same cycle; no done; after release, the next accepted byte transmits correctly.

Source files
------------

// File: rtl/serial_tx.sv
// serial_tx: asynchronous serial transmitter.
//
// Accepts a byte over a load/ready handshake and shifts it out LSB-first as
// a start / data / [even parity] / stop frame. Each bit is held for
// CLKS_PER_BIT clock cycles.
//
// Parameters
//   CLKS_PER_BIT  clock cycles per serial bit (>= 2)
//   DATA_BITS     data bits per frame (5..8)
//   PARITY_EN     1 inserts an even-parity bit after the data bits
//
// Ports
//   clk      system clock, rising edge
//   rst      asynchronous active-high reset
//   data_in  byte to send, bits [DATA_BITS-1:0] used, sampled on accept
//   load     request to send data_in (accepted when ready=1)
//   ready    high when a byte can be accepted (registered)
//   tx_out   serial line, idles high (registered)
//   done     one-cycle pulse after a frame's stop bit completes (registered)
module serial_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       load,
  output logic       ready,
  output logic       tx_out,
  output logic       done
);

  localparam int              CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]   CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]      BIT_LAST  = 3'(DATA_BITS - 1);
  localparam logic [7:0]      DATA_MASK = 8'((1 << DATA_BITS) - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            par_q, par_d;
  logic            tx_q, tx_d;
  logic            ready_q, ready_d;
  logic            done_q, done_d;
  logic            bit_end;

  assign bit_end = (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Counters stay parked at zero between frames.
        cnt_d = '0;
        bit_d = '0;
        if (load && ready_q) begin
          shift_d = data_in;
          par_d   = ^(data_in & DATA_MASK);
          state_d = S_START;
        end
      end
      S_START: begin
        cnt_d = bit_end ? '0 : cnt_q + CW'(1);
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        cnt_d = bit_end ? '0 : cnt_q + CW'(1);
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == BIT_LAST) begin
            bit_d   = '0;
            state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      S_PARITY: begin
        cnt_d = bit_end ? '0 : cnt_q + CW'(1);
        if (bit_end) state_d = S_STOP;
      end
      S_STOP: begin
        cnt_d = bit_end ? '0 : cnt_q + CW'(1);
        if (bit_end) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        bit_d   = '0;
      end
    endcase
  end

  // Line level is derived from the next state so tx_out is a plain register
  // that changes on the same edge as the state it represents.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      S_IDLE:   tx_d = 1'b1;
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = par_d;
      S_STOP:   tx_d = 1'b1;
      default:  tx_d = 1'b1;
    endcase
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  assign tx_out = tx_q;
  assign ready  = ready_q;
  assign done   = done_q;

endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx: self-checking bench for serial_tx.
// Three instances with different parameter sets share clk/rst; a frame
// model builds the expected per-cycle line level from the byte value.
module tb_serial_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din [3];
  logic       ld  [3];
  logic       rdy [3];
  logic       tx  [3];
  logic       dn  [3];

  always #5 clk = ~clk;

  serial_tx #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY_EN(0)) u0 (
    .clk(clk), .rst(rst), .data_in(din[0]), .load(ld[0]),
    .ready(rdy[0]), .tx_out(tx[0]), .done(dn[0]));
  serial_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(1)) u1 (
    .clk(clk), .rst(rst), .data_in(din[1]), .load(ld[1]),
    .ready(rdy[1]), .tx_out(tx[1]), .done(dn[1]));
  serial_tx #(.CLKS_PER_BIT(2), .DATA_BITS(5), .PARITY_EN(1)) u2 (
    .clk(clk), .rst(rst), .data_in(din[2]), .load(ld[2]),
    .ready(rdy[2]), .tx_out(tx[2]), .done(dn[2]));

  int errors = 0;
  int checks = 0;
  bit exp_q[$];

  function automatic int cpb_of(input int i);
    case (i) 0: return 16; 1: return 4; default: return 2; endcase
  endfunction
  function automatic int db_of(input int i);
    case (i) 0: return 8; 1: return 8; default: return 5; endcase
  endfunction
  function automatic int pe_of(input int i);
    case (i) 0: return 0; default: return 1; endcase
  endfunction

  // Expected line level for every cycle of one frame.
  function automatic void build(input int i, input logic [7:0] b);
    int ones = 0;
    exp_q.delete();
    for (int c = 0; c < cpb_of(i); c++) exp_q.push_back(1'b0);
    for (int j = 0; j < db_of(i); j++) begin
      bit v = b[j];
      ones += int'(v);
      for (int c = 0; c < cpb_of(i); c++) exp_q.push_back(v);
    end
    if (pe_of(i) != 0)
      for (int c = 0; c < cpb_of(i); c++) exp_q.push_back(bit'(ones % 2));
    for (int c = 0; c < cpb_of(i); c++) exp_q.push_back(1'b1);
  endfunction

  task automatic chk(input string tag, input int i, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s inst%0d observed=%b expected=%b t=%0t", tag, i, obs, expv, $time);
    end
  endtask

  task automatic outs(input string tag, input int i, input logic et, input logic er, input logic ed);
    chk({tag, ".tx"},    i, tx[i],  et);
    chk({tag, ".ready"}, i, rdy[i], er);
    chk({tag, ".done"},  i, dn[i],  ed);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_check(input int i, input int n);
    for (int c = 0; c < n; c++) begin
      outs("idle", i, 1'b1, 1'b1, 1'b0);
      step();
    end
  endtask

  task automatic start_load(input int i, input logic [7:0] b);
    ld[i]  = 1'b1;
    din[i] = b;
  endtask

  // Expects load/data already driven; the next edge is the accept edge.
  // busy_k: cycle at which to pulse a stray load of 8'h3C (-1 = none).
  // abort_k: cycle at which to assert rst mid-frame (-1 = none).
  // keep: hold load high with nb so the next frame starts back-to-back.
  task automatic frame(input int i, input logic [7:0] b, input int busy_k,
                       input int abort_k, input bit keep, input logic [7:0] nb);
    build(i, b);
    step();
    if (keep) din[i] = nb;
    else begin
      ld[i]  = 1'b0;
      din[i] = 8'($urandom);
    end
    for (int k = 0; k < exp_q.size(); k++) begin
      outs("frame", i, exp_q[k], 1'b0, 1'b0);
      if (busy_k >= 0 && k == busy_k) begin
        ld[i]  = 1'b1;
        din[i] = 8'h3C;
      end
      if (busy_k >= 0 && k == busy_k + 1) ld[i] = 1'b0;
      if (k == abort_k) begin
        #2 rst = 1'b1;
        #1 outs("rst_async", i, 1'b1, 1'b1, 1'b0);
        return;
      end
      step();
    end
    outs("frame_end", i, 1'b1, 1'b1, 1'b1);
    if (!keep) begin
      ld[i] = 1'b0;
      step();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] b, nb;
    bit keep;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ld[i]  = 1'b0;
      din[i] = 8'h00;
    end
    #1;
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < 3; i++) outs("in_reset", i, 1'b1, 1'b1, 1'b0);
      step();
    end
    rst = 1'b0;
    for (int c = 0; c < 200; c++) begin
      for (int i = 0; i < 3; i++) outs("post_reset", i, 1'b1, 1'b1, 1'b0);
      step();
    end

    // Basic frame.
    start_load(0, 8'hA5);
    frame(0, 8'hA5, -1, -1, 1'b0, 8'h00);
    idle_check(0, 3);

    // Parity frames.
    start_load(1, 8'h07);
    frame(1, 8'h07, -1, -1, 1'b0, 8'h00);
    idle_check(1, 2);
    start_load(1, 8'h03);
    frame(1, 8'h03, -1, -1, 1'b0, 8'h00);
    idle_check(1, 2);

    // Back-to-back with load held high.
    start_load(0, 8'h00);
    frame(0, 8'h00, -1, -1, 1'b1, 8'hFF);
    frame(0, 8'hFF, -1, -1, 1'b0, 8'h00);
    idle_check(0, 5);

    // Stray load while busy must be dropped.
    start_load(0, 8'h55);
    frame(0, 8'h55, 30, -1, 1'b0, 8'h00);
    idle_check(0, 200);

    // Reset during data bit 4 (cycles 80..95 after accept).
    start_load(0, 8'h00);
    frame(0, 8'h00, -1, 88, 1'b0, 8'h00);
    ld[0] = 1'b0;
    for (int c = 0; c < 2; c++) begin
      step();
      for (int i = 0; i < 3; i++) outs("rst_hold", i, 1'b1, 1'b1, 1'b0);
    end
    rst = 1'b0;
    idle_check(0, 20);
    start_load(0, 8'hC3);
    frame(0, 8'hC3, -1, -1, 1'b0, 8'h00);
    idle_check(0, 2);

    // Randomized frames on every instance, random back-to-back chaining.
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom);
      start_load(i, b);
      for (int r = 0; r < 4; r++) begin
        nb   = 8'($urandom);
        keep = (r < 3) && ($urandom_range(0, 1) == 1);
        frame(i, b, -1, -1, keep, nb);
        if (!keep) begin
          idle_check(i, $urandom_range(1, 3));
          if (r < 3) start_load(i, nb);
        end
        b = nb;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
